fb_frame_ctrl: RTL and testbench
================================

FB_FRAME_CTRL -- requirements
Module: fb_frame_ctrl

Interface
REQ-001 SHALL have port: clock  input  1  single clock domain for the block; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-003 SHALL have port: io_ppu_pixel  input  2  pixel shade from the Gameboy PPU.
REQ-004 SHALL have port: io_ppu_valid  input  1  io_ppu_pixel is valid this cycle.
REQ-005 SHALL have port: io_ppu_hblank  input  1  PPU is in horizontal blank.
REQ-006 SHALL have port: io_ppu_vblank  input  1  PPU is in vertical blank.
REQ-007 SHALL have port: io_ppu_lcdEnable  input  1  LCD is enabled.
REQ-008 SHALL have port: fb_write_en  output  1  framebuffer write strobe.
REQ-009 SHALL have port: fb_write_addr  output  17  write address {bank, y[7:0], x[7:0]}.
REQ-010 SHALL have port: fb_write_data  output  2  write data.
REQ-011 SHALL have port: display_bank  output  1  bank the HDMI reader scans; the write bank is always ~display_bank.
REQ-012 SHALL have port: frame_done  output  1  one-cycle pulse on each bank swap.
REQ-013 SHALL have port: clear_busy  output  1  high while in state CLEAR.

Function
REQ-014 SHALL implement the states IDLE, DRAW and CLEAR.
REQ-015 SHALL register prev_hblank, prev_vblank and prev_lcdEnable every cycle; rising and falling edges are computed from current input versus previous value.
REQ-016 IDLE: on a vblank falling edge with io_ppu_lcdEnable=1 -> DRAW with x=0, y=0; otherwise stay in IDLE with no writes.
REQ-017 DRAW: when io_ppu_valid=1 with x<160 and y<144, SHALL on the next cycle present fb_write_en=1, fb_write_addr={~display_bank,y,x} and fb_write_data=io_ppu_pixel (latency 1), and increment x.
REQ-018 DRAW: valid with x>=160 or y>=144 SHALL be dropped with no write; x saturates at 160.
REQ-019 DRAW: on an hblank rising edge, x<=0 and y<=y+1, saturating at 144.
REQ-020 Valid and hblank rise in the same cycle: the pixel SHALL be written at the pre-update (x,y), then the hblank counter update applies.
REQ-021 DRAW: on a vblank rising edge, display_bank SHALL toggle, frame_done SHALL pulse for 1 cycle, and the state -> IDLE; a pixel valid in that same cycle SHALL still be written to the old write bank.
REQ-022 A lcdEnable falling edge in IDLE or DRAW SHALL take priority over all other events and -> CLEAR with x=0, y=0.
REQ-023 CLEAR: SHALL write data 0 to {~display_bank,y,x} once per cycle, x 0..159 inner and y 0..143 outer, 23040 writes total.
REQ-024 CLEAR: after the write to (159,143), display_bank SHALL toggle, frame_done SHALL pulse for 1 cycle, and the state -> IDLE.
REQ-025 CLEAR: SHALL ignore PPU inputs, including lcdEnable rising and vblank edges; the clear always completes.
REQ-026 fb_write_en SHALL be 0 in every cycle without a qualifying write.
REQ-027 frame_done SHALL never be high for two consecutive cycles.

Reset
REQ-028 On reset assertion, state=IDLE, x=0, y=0, display_bank=1, fb_write_en=0, fb_write_addr=0, fb_write_data=0, frame_done=0, clear_busy=0, and all prev_* registers=0, asynchronously.
REQ-029 Reset asserted mid-DRAW or mid-CLEAR SHALL abort the operation with no further writes and no bank swap.
REQ-030 After reset release, the first frame SHALL start only on a vblank falling edge.

Verification
REQ-031 Reset, then one vblank fall and 144 lines of 160 valid pixels each separated by hblank pulses, then vblank rise -> exactly 23040 writes to bank 0, last address {0,143,159}, display_bank=0, exactly one frame_done pulse.
REQ-032 165 valid pixels on line 0 -> writes for x=0..159 only; x=160..164 produce no write.
REQ-033 Valid and hblank rise in the same cycle at x=5, y=2 -> write at {wb,2,5}, next valid writes {wb,3,0}.
REQ-034 lcdEnable falls mid-line 40 -> clear_busy=1 for 23040 cycles with data 0 across all addresses of the write bank, lcdEnable re-rise ignored, then display_bank toggles and frame_done pulses.
REQ-035 Reset asserted at write 1000 of a frame -> fb_write_en=0 immediately, display_bank=1, no frame_done, state IDLE.
REQ-036 Two consecutive full frames -> display_bank sequence 1->0->1, and the second frame's writes target bank 1.

Source files
------------

// File: rtl/fb_frame_ctrl.sv
// Framebuffer write controller for a Gameboy PPU pixel stream. Pixels are written
// into the bank that is not on display; the banks swap on each completed frame or clear.
module fb_frame_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  io_ppu_pixel,
  input  logic        io_ppu_valid,
  input  logic        io_ppu_hblank,
  input  logic        io_ppu_vblank,
  input  logic        io_ppu_lcdEnable,
  output logic        fb_write_en,
  output logic [16:0] fb_write_addr,
  output logic [1:0]  fb_write_data,
  output logic        display_bank,
  output logic        frame_done,
  output logic        clear_busy
);

  localparam logic [7:0] Width  = 8'd160;
  localparam logic [7:0] Height = 8'd144;
  localparam logic [7:0] LastX  = 8'd159;
  localparam logic [7:0] LastY  = 8'd143;

  typedef enum logic [1:0] {StIdle, StDraw, StClear} state_e;

  state_e      state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic        bank_q, bank_d;
  logic        we_q, we_d;
  logic [16:0] addr_q, addr_d;
  logic [1:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        prev_hblank_q, prev_vblank_q, prev_lcd_q;

  logic hb_rise, vb_rise, vb_fall, lcd_fall, pix_ok, clear_last;

  assign hb_rise    = io_ppu_hblank & ~prev_hblank_q;
  assign vb_rise    = io_ppu_vblank & ~prev_vblank_q;
  assign vb_fall    = ~io_ppu_vblank & prev_vblank_q;
  assign lcd_fall   = ~io_ppu_lcdEnable & prev_lcd_q;
  assign pix_ok     = io_ppu_valid && (x_q < Width) && (y_q < Height);
  assign clear_last = (x_q == LastX) && (y_q == LastY);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      x_q           <= 8'd0;
      y_q           <= 8'd0;
      bank_q        <= 1'b1;
      we_q          <= 1'b0;
      addr_q        <= 17'd0;
      data_q        <= 2'd0;
      done_q        <= 1'b0;
      prev_hblank_q <= 1'b0;
      prev_vblank_q <= 1'b0;
      prev_lcd_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      bank_q        <= bank_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      done_q        <= done_d;
      prev_hblank_q <= io_ppu_hblank;
      prev_vblank_q <= io_ppu_vblank;
      prev_lcd_q    <= io_ppu_lcdEnable;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (lcd_fall) begin
          state_d = StClear;
        end else if (vb_fall && io_ppu_lcdEnable) begin
          state_d = StDraw;
        end
      end
      StDraw: begin
        if (lcd_fall) begin
          state_d = StClear;
        end else if (vb_rise) begin
          state_d = StIdle;
        end
      end
      StClear: begin
        if (clear_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Write strobe/address/data are registered, so every write lands one cycle after its event
  // and always uses the bank that was hidden when the event occurred.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    bank_d = bank_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (lcd_fall || (vb_fall && io_ppu_lcdEnable)) begin
          x_d = 8'd0;
          y_d = 8'd0;
        end
      end
      StDraw: begin
        if (lcd_fall) begin
          x_d = 8'd0;
          y_d = 8'd0;
        end else begin
          if (pix_ok) begin
            we_d   = 1'b1;
            addr_d = {~bank_q, y_q, x_q};
            data_d = io_ppu_pixel;
            x_d    = x_q + 8'd1;
          end
          // Line advance overrides the pixel increment but the pixel above used the old x,y.
          if (hb_rise) begin
            x_d = 8'd0;
            y_d = (y_q < Height) ? y_q + 8'd1 : y_q;
          end
          if (vb_rise) begin
            bank_d = ~bank_q;
            done_d = 1'b1;
          end
        end
      end
      StClear: begin
        we_d   = 1'b1;
        addr_d = {~bank_q, y_q, x_q};
        data_d = 2'd0;
        if (x_q == LastX) begin
          x_d = 8'd0;
          if (y_q == LastY) begin
            y_d    = 8'd0;
            bank_d = ~bank_q;
            done_d = 1'b1;
          end else begin
            y_d = y_q + 8'd1;
          end
        end else begin
          x_d = x_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    fb_write_en   = we_q;
    fb_write_addr = addr_q;
    fb_write_data = data_q;
    display_bank  = bank_q;
    frame_done    = done_q;
    clear_busy    = (state_q == StClear);
  end

endmodule

// File: tb/tb_fb_frame_ctrl.sv
// Self-checking bench for fb_frame_ctrl: a directed vector table, scenario sequences and
// randomized traffic, all compared cycle by cycle against a behavioural frame model.
module tb_fb_frame_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  pix = 2'd0;
  logic        valid = 1'b0, hb = 1'b0, vb = 1'b0, lcd = 1'b0;
  logic        fb_write_en;
  logic [16:0] fb_write_addr;
  logic [1:0]  fb_write_data;
  logic        display_bank, frame_done, clear_busy;

  fb_frame_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .io_ppu_pixel    (pix),
    .io_ppu_valid    (valid),
    .io_ppu_hblank   (hb),
    .io_ppu_vblank   (vb),
    .io_ppu_lcdEnable(lcd),
    .fb_write_en     (fb_write_en),
    .fb_write_addr   (fb_write_addr),
    .fb_write_data   (fb_write_data),
    .display_bank    (display_bank),
    .frame_done      (frame_done),
    .clear_busy      (clear_busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a frame is a 160x144 raster; a clear walks a linear pixel index.
  localparam int MIdle = 0, MDraw = 1, MClear = 2;
  localparam int Pixels = 160 * 144;
  int mode, px, py, cidx, e_addr, e_data;
  bit m_bank, p_hb, p_vb, p_lcd, e_we, e_done;

  // Observations of the DUT
  int wr_cnt, done_cnt, last_addr, nonzero_cnt;
  int bank_wr[2];
  logic last_done;

  task automatic model_reset();
    mode = MIdle; px = 0; py = 0; cidx = 0; m_bank = 1'b1;
    p_hb = 0; p_vb = 0; p_lcd = 0; e_we = 0; e_done = 0;
  endtask

  task automatic model_step();
    bit hr, vr, vf, lf;
    hr = hb && !p_hb;
    vr = vb && !p_vb;
    vf = !vb && p_vb;
    lf = !lcd && p_lcd;
    e_we = 0;
    e_done = 0;
    if (mode == MClear) begin
      e_we = 1;
      e_addr = ((m_bank ? 0 : 1) << 16) | ((cidx / 160) << 8) | (cidx % 160);
      e_data = 0;
      cidx++;
      if (cidx == Pixels) begin
        m_bank = !m_bank; e_done = 1; mode = MIdle;
      end
    end else if (lf) begin
      mode = MClear; cidx = 0; px = 0; py = 0;
    end else if (mode == MIdle) begin
      if (vf && lcd) begin
        mode = MDraw; px = 0; py = 0;
      end
    end else begin
      if (valid && px < 160 && py < 144) begin
        e_we = 1;
        e_addr = ((m_bank ? 0 : 1) << 16) | (py << 8) | px;
        e_data = pix;
        px++;
      end
      if (hr) begin
        px = 0;
        if (py < 144) py++;
      end
      if (vr) begin
        m_bank = !m_bank; e_done = 1; mode = MIdle;
      end
    end
    p_hb = hb; p_vb = vb; p_lcd = lcd;
  endtask

  task automatic zero_cnt();
    wr_cnt = 0; done_cnt = 0; last_addr = -1; nonzero_cnt = 0;
    bank_wr[0] = 0; bank_wr[1] = 0;
  endtask

  task automatic drive(input bit v, input bit [1:0] p, input bit h, input bit vbl, input bit l);
    valid = v; pix = p; hb = h; vb = vbl; lcd = l;
  endtask

  // One clock: model advances at the edge, DUT outputs compared at the following negedge.
  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    chk("write_en", fb_write_en, e_we);
    if (e_we) begin
      chk("write_addr", fb_write_addr, e_addr);
      chk("write_data", fb_write_data, e_data);
    end
    chk("display_bank", display_bank, m_bank);
    chk("frame_done", frame_done, e_done);
    chk("clear_busy", clear_busy, mode == MClear);
    chk("done_back_to_back", frame_done & last_done, 0);
    last_done = frame_done;
    if (fb_write_en) begin
      wr_cnt++;
      last_addr = fb_write_addr;
      bank_wr[fb_write_addr[16]]++;
      if (fb_write_data != 2'd0) nonzero_cnt++;
    end
    if (frame_done) done_cnt++;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("reset_write_en", fb_write_en, 0);
    chk("reset_bank", display_bank, 1);
    chk("reset_done", frame_done, 0);
    chk("reset_busy", clear_busy, 0);
    chk("reset_addr", fb_write_addr, 0);
    chk("reset_data", fb_write_data, 0);
    model_reset();
    last_done = 1'b0;
    drive(0, 0, 0, 0, 0);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic start_frame();
    drive(0, 0, 0, 1, 1); tick(); tick();
    drive(0, 0, 0, 0, 1); tick();
  endtask

  task automatic line(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1, 2'($urandom), 0, 0, 1);
      tick();
    end
    drive(0, 0, 1, 0, 1); tick(); tick();
    drive(0, 0, 0, 0, 1); tick();
  endtask

  task automatic full_frame();
    start_frame();
    for (int y = 0; y < 144; y++) line(160);
    drive(0, 0, 0, 1, 1); tick();
    tick();
  endtask

  typedef struct {
    bit v; bit [1:0] p; bit h; bit vbl; bit l;
    bit we; bit [16:0] addr; bit [1:0] data; bit bank; bit done; bit busy;
  } vec_t;
  vec_t tbl[15];

  initial begin
    tbl[0]  = '{0, 0, 0, 1, 1, 0, 17'h00000, 0, 1, 0, 0};
    tbl[1]  = '{1, 3, 0, 1, 1, 0, 17'h00000, 0, 1, 0, 0};
    tbl[2]  = '{1, 2, 0, 0, 1, 0, 17'h00000, 0, 1, 0, 0};
    tbl[3]  = '{1, 1, 0, 0, 1, 1, 17'h00000, 1, 1, 0, 0};
    tbl[4]  = '{1, 2, 0, 0, 1, 1, 17'h00001, 2, 1, 0, 0};
    tbl[5]  = '{0, 0, 1, 0, 1, 0, 17'h00000, 0, 1, 0, 0};
    tbl[6]  = '{1, 3, 1, 0, 1, 1, 17'h00100, 3, 1, 0, 0};
    tbl[7]  = '{1, 0, 0, 0, 1, 1, 17'h00101, 0, 1, 0, 0};
    tbl[8]  = '{1, 1, 0, 1, 1, 1, 17'h00102, 1, 0, 1, 0};
    tbl[9]  = '{0, 0, 0, 1, 1, 0, 17'h00000, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 1, 0, 17'h00000, 0, 0, 0, 0};
    tbl[11] = '{1, 2, 0, 0, 1, 1, 17'h10000, 2, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 17'h00000, 0, 0, 0, 1};
    tbl[13] = '{0, 0, 0, 0, 0, 1, 17'h10000, 0, 0, 0, 1};
    tbl[14] = '{0, 0, 0, 0, 0, 1, 17'h10001, 0, 0, 0, 1};

    last_done = 1'b0;
    model_reset();
    @(negedge clock);
    do_reset();

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].p, tbl[i].h, tbl[i].vbl, tbl[i].l);
      tick();
      chk($sformatf("tbl%0d_we", i), fb_write_en, tbl[i].we);
      if (tbl[i].we) begin
        chk($sformatf("tbl%0d_addr", i), fb_write_addr, tbl[i].addr);
        chk($sformatf("tbl%0d_data", i), fb_write_data, tbl[i].data);
      end
      chk($sformatf("tbl%0d_bank", i), display_bank, tbl[i].bank);
      chk($sformatf("tbl%0d_done", i), frame_done, tbl[i].done);
      chk($sformatf("tbl%0d_busy", i), clear_busy, tbl[i].busy);
    end

    // Reset mid-clear aborts it
    do_reset();
    tick();
    chk("abort_clear_busy", clear_busy, 0);

    // Two full frames: bank 1 -> 0 -> 1
    zero_cnt();
    full_frame();
    chk("f1_writes", wr_cnt, Pixels);
    chk("f1_bank0_writes", bank_wr[0], Pixels);
    chk("f1_last_addr", last_addr, {1'b0, 8'd143, 8'd159});
    chk("f1_display_bank", display_bank, 0);
    chk("f1_done_pulses", done_cnt, 1);
    zero_cnt();
    full_frame();
    chk("f2_bank1_writes", bank_wr[1], Pixels);
    chk("f2_last_addr", last_addr, {1'b1, 8'd143, 8'd159});
    chk("f2_display_bank", display_bank, 1);
    chk("f2_done_pulses", done_cnt, 1);

    // Over-long line, then valid coinciding with hblank rise
    do_reset();
    start_frame();
    zero_cnt();
    for (int i = 0; i < 165; i++) begin
      drive(1, 2'($urandom), 0, 0, 1);
      tick();
    end
    chk("long_line_writes", wr_cnt, 160);
    chk("long_line_last", last_addr, {1'b0, 8'd0, 8'd159});
    drive(0, 0, 1, 0, 1); tick();
    drive(0, 0, 0, 0, 1); tick();
    line(0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'($urandom), 0, 0, 1);
      tick();
    end
    drive(1, 2'd3, 1, 0, 1); tick();
    chk("same_cycle_we", fb_write_en, 1);
    chk("same_cycle_addr", fb_write_addr, {1'b0, 8'd2, 8'd5});
    drive(1, 2'd1, 0, 0, 1); tick();
    chk("after_hblank_addr", fb_write_addr, {1'b0, 8'd3, 8'd0});

    // lcdEnable falls mid-line 40; re-rise and PPU edges during the clear are ignored
    for (int y = 3; y < 40; y++) line(160);
    for (int i = 0; i < 70; i++) begin
      drive(1, 2'($urandom), 0, 0, 1);
      tick();
    end
    zero_cnt();
    drive(1, 2'd3, 0, 0, 0); tick();
    begin
      int busy_cnt = 0;
      for (int i = 0; i < 23100; i++) begin
        if (!clear_busy) break;
        busy_cnt++;
        drive($urandom % 2, 2'($urandom), ($urandom % 50) == 0, ($urandom % 300) < 5, i > 100);
        tick();
      end
      chk("clear_busy_cycles", busy_cnt, Pixels);
    end
    chk("clear_writes", bank_wr[0], Pixels);
    chk("clear_nonzero_data", nonzero_cnt, 0);
    chk("clear_last_addr", last_addr, {1'b0, 8'd143, 8'd159});
    chk("clear_done_pulses", done_cnt, 1);
    chk("clear_display_bank", display_bank, 0);

    // Reset at write 1000, then no drawing until a vblank fall
    do_reset();
    start_frame();
    zero_cnt();
    for (int i = 0; i < 2000 && wr_cnt < 1000; i++) begin
      drive(1, 2'($urandom), (i % 170) >= 166, 0, 1);
      tick();
    end
    chk("mid_frame_reached_1000", wr_cnt, 1000);
    do_reset();
    zero_cnt();
    for (int i = 0; i < 20; i++) begin
      drive(1, 2'($urandom), i == 10, 0, 1);
      tick();
    end
    chk("post_reset_no_writes", wr_cnt, 0);
    chk("post_reset_no_done", done_cnt, 0);
    start_frame();
    drive(1, 2'd2, 0, 0, 1); tick();
    chk("post_reset_first_addr", fb_write_addr, {1'b0, 8'd0, 8'd0});

    // Randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      drive(($urandom % 4) != 0, 2'($urandom), ($urandom % 40) == 0,
            ($urandom % 100) < ((i % 400) < 20 ? 60 : 1), 1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
